// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants for the commit trace buffer: default data width and the
// layout of one buffered commit record {pc, instr, next_pc, seq}.
package commit_trace_buffer_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int SEQ_WIDTH          = 32;

   // Total record width for a given PC/instruction width.
   function automatic int rec_width(input int dw);
      return 3 * dw + SEQ_WIDTH;
   endfunction

   // Field offsets inside a record, seq in the low bits.
   function automatic int next_pc_lsb(input int dw);
      return SEQ_WIDTH + 0 * dw;
   endfunction

   function automatic int instr_lsb(input int dw);
      return SEQ_WIDTH + dw;
   endfunction

   function automatic int pc_lsb(input int dw);
      return SEQ_WIDTH + 2 * dw;
   endfunction

endpackage

// File: rtl/commit_trace_buffer_sync_fifo.sv
// Synchronous FIFO with a registered read head: the head record is a flop,
// so rd_data never depends combinationally on wr_data.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [AW:0]      count;
   logic             wr_fire;
   logic             rd_fire;
   logic             head_load;
   logic [WIDTH-1:0] head_src;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_fire = rd_en && !empty;
   assign wr_fire = wr_en && (!full || rd_fire);

   // Select the record that becomes the head after this edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_nxt = rd_ptr;
      head_src   = '0;
      head_load  = rd_fire || (empty && wr_fire);
      if (rd_fire) begin
         rd_ptr_nxt = rd_ptr + 1'b1;
      end
      // The new head is the word being written when the FIFO holds at most one entry.
      if (wr_fire && (wr_ptr == rd_ptr_nxt)) begin
         head_src = wr_data;
      end else begin
         head_src = mem[rd_ptr_nxt];
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; validity is tracked by count, and an unreset array maps to plain RAM.
      if (wr_fire) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered head.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (wr_fire && !rd_fire) begin
            count <= count + 1'b1;
         end else if (!wr_fire && rd_fire) begin
            count <= count - 1'b1;
         end
         if (head_load) begin
            rd_data <= head_src;
         end
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Difftest commit trace buffer: queues retired-instruction records for the
// simulator-side driver, counts retirements, checks PC continuity and runs
// a watchdog on commit activity.
module commit_trace_buffer
   import commit_trace_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int DEPTH      = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_pc,
   input  logic [DATA_WIDTH-1:0]   in_instr,
   input  logic [DATA_WIDTH-1:0]   in_next_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_pc,
   output logic [DATA_WIDTH-1:0]   out_instr,
   output logic [DATA_WIDTH-1:0]   out_next_pc,
   output logic [31:0]             out_seq,
   output logic [$clog2(DEPTH):0]  level,
   output logic [63:0]             commit_count,
   output logic                    overflow,
   output logic                    chain_err,
   output logic [DATA_WIDTH-1:0]   chain_err_pc,
   output logic                    timeout
);

   localparam int REC_W   = rec_width(DATA_WIDTH);
   localparam int NPC_LSB = next_pc_lsb(DATA_WIDTH);
   localparam int INS_LSB = instr_lsb(DATA_WIDTH);
   localparam int PC_LSB  = pc_lsb(DATA_WIDTH);
   localparam int IW      = $clog2(TIMEOUT + 1);

   logic             full;
   logic             empty;
   logic             deq;
   logic             enq;
   logic             drop;
   logic [REC_W-1:0] wr_rec;
   logic [REC_W-1:0] head_rec;

   logic                  have_prev;
   logic [DATA_WIDTH-1:0] prev_next_pc;
   logic [IW-1:0]         idle_cnt;
   logic [IW-1:0]         idle_nxt;

   // A full FIFO still accepts a commit when its head leaves in the same cycle.
   assign deq       = !empty && out_ready;
   assign enq       = in_valid && (!full || deq);
   assign drop      = in_valid && full && !deq;
   assign out_valid = !empty;
   assign wr_rec    = {in_pc, in_instr, in_next_pc, commit_count[SEQ_WIDTH-1:0]};

   assign out_seq     = head_rec[SEQ_WIDTH-1:0];
   assign out_next_pc = head_rec[NPC_LSB +: DATA_WIDTH];
   assign out_instr   = head_rec[INS_LSB +: DATA_WIDTH];
   assign out_pc      = head_rec[PC_LSB  +: DATA_WIDTH];

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enq),
      .wr_data (wr_rec),
      .rd_en   (deq),
      .rd_data (head_rec),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // Next idle count: cleared by a commit, saturating at TIMEOUT.
   always_comb begin
      idle_nxt = idle_cnt;
      if (in_valid) begin
         idle_nxt = '0;
      end else if (idle_cnt != IW'(TIMEOUT)) begin
         idle_nxt = idle_cnt + 1'b1;
      end
   end

   // Retire counter and sticky overflow; dropped commits still count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_count <= '0;
         overflow     <= 1'b0;
      end else begin
         if (in_valid) begin
            commit_count <= commit_count + 64'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // PC chain check across every commit, keeping the first offending PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         have_prev    <= 1'b0;
         prev_next_pc <= '0;
         chain_err    <= 1'b0;
         chain_err_pc <= '0;
      end else if (in_valid) begin
         have_prev    <= 1'b1;
         prev_next_pc <= in_next_pc;
         if (have_prev && (in_pc != prev_next_pc)) begin
            chain_err <= 1'b1;
            if (!chain_err) begin
               chain_err_pc <= in_pc;
            end
         end
      end
   end

   // Commit watchdog, armed once the first commit has been seen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt;
         if (have_prev && !in_valid && (idle_nxt == IW'(TIMEOUT))) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: a scoreboard queue of records
// expected at the output, a small reference model of counters and flags,
// a vector table for the overflow scenario and short hand-written sequences.
module tb_commit_trace_buffer;

   localparam int DW      = 32;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_pc = '0;
   logic [DW-1:0] in_instr = '0;
   logic [DW-1:0] in_next_pc = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_pc;
   logic [DW-1:0] out_instr;
   logic [DW-1:0] out_next_pc;
   logic [31:0]   out_seq;
   logic [$clog2(DEPTH):0] level;
   logic [63:0]   commit_count;
   logic          overflow;
   logic          chain_err;
   logic [DW-1:0] chain_err_pc;
   logic          timeout;

   commit_trace_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_pc        (in_pc),
      .in_instr     (in_instr),
      .in_next_pc   (in_next_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_next_pc  (out_next_pc),
      .out_seq      (out_seq),
      .level        (level),
      .commit_count (commit_count),
      .overflow     (overflow),
      .chain_err    (chain_err),
      .chain_err_pc (chain_err_pc),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] npc;
      logic [31:0] seq;
   } rec_t;

   typedef struct {
      bit          v;
      bit          rdy;
      logic [31:0] pc;
      logic [31:0] npc;
      int          exp_level;
      bit          exp_ovf;
   } vec_t;

   rec_t sb[$];
   vec_t vecs[11];

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int          m_level;
   logic [63:0] m_cc;
   bit          m_ovf;
   bit          m_have_prev;
   bit          m_chain;
   logic [31:0] m_prev_npc;
   logic [31:0] m_chain_pc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
   endfunction

   task automatic model_clear();
      m_level     = 0;
      m_cc        = '0;
      m_ovf       = 1'b0;
      m_have_prev = 1'b0;
      m_chain     = 1'b0;
      m_prev_npc  = '0;
      m_chain_pc  = '0;
      sb.delete();
   endtask

   // Assert reset, clear the model, release on a falling edge.
   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      model_clear();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock cycle of stimulus, starting and ending on a falling edge.
   task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] npc, input bit rdy);
      rec_t r;
      bit   deq;
      bit   accept;
      check("out_valid", out_valid, m_level != 0);
      deq = (m_level != 0) && rdy;
      if (deq) begin
         r = sb.pop_front();
         check("out_pc", out_pc, r.pc);
         check("out_instr", out_instr, r.instr);
         check("out_next_pc", out_next_pc, r.npc);
         check("out_seq", out_seq, r.seq);
      end
      in_valid   = v;
      in_pc      = pc;
      in_instr   = instr_of(pc);
      in_next_pc = npc;
      out_ready  = rdy;
      if (v) begin
         accept = (m_level < DEPTH) || deq;
         if (accept) begin
            sb.push_back('{pc: pc, instr: instr_of(pc), npc: npc, seq: m_cc[31:0]});
            if (!deq) m_level++;
         end else begin
            m_ovf = 1'b1;
         end
         if (m_have_prev && pc != m_prev_npc) begin
            if (!m_chain) m_chain_pc = pc;
            m_chain = 1'b1;
         end
         m_have_prev = 1'b1;
         m_prev_npc  = npc;
         m_cc        = m_cc + 64'd1;
      end else if (deq) begin
         m_level--;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("level", level, m_level);
      check("commit_count", commit_count, m_cc);
      check("overflow", overflow, m_ovf);
      check("chain_err", chain_err, m_chain);
      check("chain_err_pc", chain_err_pc, m_chain_pc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      // Overflow scenario vectors: ready held low, ten sequential commits,
      // then one commit together with a dequeue on the full FIFO.
      for (int i = 0; i < 10; i++) begin
         vecs[i] = '{v: 1'b1, rdy: 1'b0,
                     pc:  32'h8000_0000 + 32'(4 * i),
                     npc: 32'h8000_0004 + 32'(4 * i),
                     exp_level: (i < 8) ? i + 1 : 8,
                     exp_ovf:   (i >= 8)};
      end
      vecs[10] = '{v: 1'b1, rdy: 1'b1, pc: 32'h8000_0028, npc: 32'h8000_002C,
                   exp_level: 8, exp_ovf: 1'b1};

      model_clear();

      // Reset state.
      rst = 1'b0;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_commit_count", commit_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_chain_err", chain_err, 0);
      check("rst_chain_err_pc", chain_err_pc, 0);
      check("rst_timeout", timeout, 0);
      check("rst_out_seq", out_seq, 0);
      @(negedge clk);
      rst = 1'b1;

      // Three in-order commits drained with ready high.
      step(1'b1, 32'h8000_0000, 32'h8000_0004, 1'b1);
      step(1'b1, 32'h8000_0004, 32'h8000_0008, 1'b1);
      step(1'b1, 32'h8000_0008, 32'h8000_000C, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1);
      check("three_commit_count", commit_count, 3);
      check("three_chain_err", chain_err, 0);
      check("three_level", level, 0);

      // Overflow: vector table, then drain.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].v, vecs[i].pc, vecs[i].npc, vecs[i].rdy);
         check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
         check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
         if (i == 9) check("ovf_commit_count", commit_count, 10);
      end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
      check("ovf_drained_level", level, 0);
      check("ovf_drained_valid", out_valid, 0);

      // Full FIFO with enqueue and dequeue in the same cycle: no drop.
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h8000_0004 + 32'(4 * i), 1'b0);
      step(1'b1, 32'h8000_0020, 32'h8000_0024, 1'b1);
      check("simul_level", level, 8);
      check("simul_overflow", overflow, 0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

      // Chain discontinuity, first PC captured only.
      do_reset();
      step(1'b1, 32'h8000_0000, 32'h8000_0010, 1'b1);
      step(1'b1, 32'h8000_0004, 32'h8000_0008, 1'b1);
      check("chain_first_err", chain_err, 1);
      check("chain_first_pc", chain_err_pc, 32'h8000_0004);
      step(1'b1, 32'h8000_0020, 32'h8000_0024, 1'b1);
      check("chain_second_pc", chain_err_pc, 32'h8000_0004);
      step(1'b0, 32'h0, 32'h0, 1'b1);

      // Watchdog: stays quiet with no commit, then fires exactly TIMEOUT cycles after one.
      do_reset();
      repeat (TIMEOUT + 5) @(negedge clk);
      check("wd_no_commit", timeout, 0);
      step(1'b1, 32'h8000_0000, 32'h8000_0004, 1'b0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == TIMEOUT - 1) check("wd_before_limit", timeout, 0);
         if (k == TIMEOUT)     check("wd_at_limit", timeout, 1);
      end

      // Reset mid-drain with five entries and a chain error pending.
      do_reset();
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h8000_0004 + 32'(4 * i), 1'b0);
      step(1'b1, 32'h9000_0000, 32'h9000_0004, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1);
      check("pre_rst_level", level, 5);
      check("pre_rst_chain", chain_err, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_commit_count", commit_count, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_chain_err", chain_err, 0);
      check("mid_rst_chain_err_pc", chain_err_pc, 0);
      check("mid_rst_timeout", timeout, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 32'h0, 32'h0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
